// File: rtl/mux_shift_pkg.sv
// Shared encodings for the multicycle shift unit: operation codes and FSM state codes.
// Imported by the interface, the top module and the testbench.
package mux_shift_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_SLL = 2'b00;
  localparam op_t OP_SRL = 2'b01;
  localparam op_t OP_SRA = 2'b10;
  localparam op_t OP_ROR = 2'b11;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

endpackage

// File: rtl/mux_shift_unit_if.sv
// Operand/result bundle between the control FSM (master) and mux_shift_unit (slave).
// With MUX_SHIFT_ABORT_EN defined the bundle also carries the abort request.
interface mux_shift_unit_if
  import mux_shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int AMT_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
);

  logic                     start;
  op_t                      op;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*AMT_W-1:0] amt_src;
  logic [DATA_W-1:0]        data_in;
  logic [DATA_W-1:0]        data_out;
  logic                     busy;
  logic                     done;
  logic                     sel_err;
`ifdef MUX_SHIFT_ABORT_EN
  logic                     abort;

  modport master (
    output start, op, sel, amt_src, data_in, abort,
    input  data_out, busy, done, sel_err
  );

  modport slave (
    input  start, op, sel, amt_src, data_in, abort,
    output data_out, busy, done, sel_err
  );
`else
  modport master (
    output start, op, sel, amt_src, data_in,
    input  data_out, busy, done, sel_err
  );

  modport slave (
    input  start, op, sel, amt_src, data_in,
    output data_out, busy, done, sel_err
  );
`endif

endinterface

// File: rtl/mux_nto1_param.sv
// Generic N-to-1 mux over a flattened input bus; err flags a select with no matching source.
// When err is set the output is forced to zero.
module mux_nto1_param #(
  parameter int W     = 5,
  parameter int N     = 3,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_flat,
  output logic [W-1:0]     out,
  output logic             err
);

  always_comb begin
    out = '0;
    err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        out = in_flat[i*W +: W];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_shift_unit.sv
// Shift unit: selects a shift amount from NUM_SRC sources, then shifts up to STEP bits per cycle.
// Optional feature macro: MUX_SHIFT_ABORT_EN (adds abort, which restores the original operand).
module mux_shift_unit
  import mux_shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int AMT_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int STEP    = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux_shift_unit_if.slave  bus
);

  // Counter width wide enough for both the remaining amount and the STEP constant.
  localparam int CW = (AMT_W > $clog2(DATA_W + 1)) ? AMT_W : $clog2(DATA_W + 1);

  generate
    if ((2 ** SEL_W) < NUM_SRC) begin : g_bad_sel_w
      $error("mux_shift_unit: SEL_W too narrow for NUM_SRC");
    end
    if (STEP < 1 || STEP > DATA_W) begin : g_bad_step
      $error("mux_shift_unit: STEP must lie in 1..DATA_W");
    end
  endgenerate

  state_t            state;
  op_t               op_q;
  logic [AMT_W-1:0]  rem;
  logic [AMT_W-1:0]  sel_amt;
  logic              sel_bad;
  logic [CW-1:0]     n;
  logic [DATA_W-1:0] shifted;
`ifdef MUX_SHIFT_ABORT_EN
  logic [DATA_W-1:0] orig;
`endif

  mux_nto1_param #(
    .W     (AMT_W),
    .N     (NUM_SRC),
    .SEL_W (SEL_W)
  ) u_amt_mux (
    .sel     (bus.sel),
    .in_flat (bus.amt_src),
    .out     (sel_amt),
    .err     (sel_bad)
  );

  always_comb begin
    n = (CW'(rem) > CW'(STEP)) ? CW'(STEP) : CW'(rem);
  end

  // One iteration of the shift; SRA re-reads the current MSB each step.
  always_comb begin
    shifted = bus.data_out;
    case (op_q)
      OP_SLL:  shifted = bus.data_out << n;
      OP_SRL:  shifted = bus.data_out >> n;
      OP_SRA:  shifted = $unsigned($signed(bus.data_out) >>> n);
      OP_ROR:  shifted = (bus.data_out >> n) | (bus.data_out << (CW'(DATA_W) - n));
      default: shifted = bus.data_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= OP_SLL;
      rem          <= '0;
      bus.data_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sel_err  <= 1'b0;
`ifdef MUX_SHIFT_ABORT_EN
      orig         <= '0;
`endif
    end else begin
      bus.done    <= 1'b0;
      bus.sel_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.data_out <= bus.data_in;
            op_q         <= bus.op;
`ifdef MUX_SHIFT_ABORT_EN
            orig         <= bus.data_in;
`endif
            rem          <= sel_bad ? '0 : sel_amt;
            bus.sel_err  <= sel_bad;
            // A bad select or zero amount skips straight to the result pulse.
            if (sel_bad || sel_amt == '0) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end else begin
              state    <= ST_SHIFT;
              bus.busy <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
`ifdef MUX_SHIFT_ABORT_EN
          if (bus.abort) begin
            state        <= ST_IDLE;
            bus.data_out <= orig;
            bus.busy     <= 1'b0;
            rem          <= '0;
          end else
`endif
          begin
            bus.data_out <= shifted;
            rem          <= rem - n[AMT_W-1:0];
            if (CW'(rem) == n) begin
              state    <= ST_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_shift_unit.sv
// Scoreboard bench for mux_shift_unit: directed ops push expectations, a monitor checks each done pulse.
// The abort scenario is compiled in only when MUX_SHIFT_ABORT_EN is defined.
module tb_mux_shift_unit;
  import mux_shift_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          busyCycles;
    int          c0;
  } exp_t;

  logic clk;
  logic reset;
  int   cycleCnt;
  int   busyRun;
  int   testsRun;
  int   failCount;
  exp_t sbQ[$];

  mux_shift_unit_if #(.DATA_W(32), .AMT_W(5), .NUM_SRC(3), .SEL_W(2)) bus ();

  mux_shift_unit #(
    .DATA_W (32),
    .AMT_W  (5),
    .NUM_SRC(3),
    .SEL_W  (2),
    .STEP   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [14:0] packSrc(input logic [4:0] a0, input logic [4:0] a1,
                                          input logic [4:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.busy) busyRun++;
        if (bus.done) begin
          if (sbQ.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL unexpected_done: got done=1, expected none (data_out %h)",
                     bus.data_out);
          end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("data_out", bus.data_out, e.data);
            checkOutput("sel_err", {31'b0, bus.sel_err}, {31'b0, e.err});
            checkOutput("done_latency", cycleCnt - e.c0, e.lat);
            checkOutput("busy_cycles", busyRun, e.busyCycles);
          end
        end else if (bus.sel_err) begin
          testsRun++;
          failCount++;
          $display("[TB] FAIL sel_err_without_done: got sel_err=1, expected 0");
        end
      end
    end
  end

  // Issues one start; junk extra start cycles carry different operands that must be ignored.
  task automatic applyStimulus(input op_t o, input logic [1:0] s, input logic [14:0] src,
                               input logic [31:0] d, input logic [31:0] expData,
                               input logic expErr, input int expLat, input int expBusy,
                               input int junk, input bit track);
    exp_t e;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.sel     = s;
    bus.amt_src = src;
    bus.data_in = d;
    e.data       = expData;
    e.err        = expErr;
    e.lat        = expLat;
    e.busyCycles = expBusy;
    e.c0         = cycleCnt;
    if (track) sbQ.push_back(e);
    @(posedge clk);
    busyRun = 0;
    @(negedge clk);
    bus.data_in = 32'hFFFF_FFFF;
    bus.sel     = 2'd0;
    bus.op      = OP_SLL;
    bus.amt_src = packSrc(5'd1, 5'd1, 5'd1);
    for (int j = 0; j < junk; j++) @(negedge clk);
    bus.start = 1'b0;
    if (track) begin
      for (int w = 0; w < 40 && sbQ.size() != 0; w++) @(negedge clk);
      if (sbQ.size() != 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL done_timeout: got %0d pending results, expected 0", sbQ.size());
        sbQ.delete();
      end
      @(negedge clk);
    end
  endtask

  initial begin
    cycleCnt    = 0;
    busyRun     = 0;
    testsRun    = 0;
    failCount   = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_SLL;
    bus.sel     = 2'd0;
    bus.amt_src = '0;
    bus.data_in = '0;
`ifdef MUX_SHIFT_ABORT_EN
    bus.abort   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", bus.data_out, 32'h0);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("reset_done", {31'b0, bus.done}, 32'h0);
    checkOutput("reset_sel_err", {31'b0, bus.sel_err}, 32'h0);
    reset = 1'b0;

    applyStimulus(OP_SLL, 2'd1, packSrc(5'd0, 5'd5, 5'd31), 32'h0000_0001, 32'h0000_0020, 1'b0, 3, 2, 0, 1'b1);
    applyStimulus(OP_SRA, 2'd2, packSrc(5'd0, 5'd5, 5'd31), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 9, 8, 0, 1'b1);
    applyStimulus(OP_SRL, 2'd2, packSrc(5'd0, 5'd5, 5'd31), 32'h8000_0000, 32'h0000_0001, 1'b0, 9, 8, 0, 1'b1);
    applyStimulus(OP_ROR, 2'd1, packSrc(5'd0, 5'd4, 5'd31), 32'h0000_00F1, 32'h1000_000F, 1'b0, 2, 1, 0, 1'b1);
    applyStimulus(OP_SLL, 2'd3, packSrc(5'd0, 5'd4, 5'd31), 32'h1234_5678, 32'h1234_5678, 1'b1, 1, 0, 0, 1'b1);
    applyStimulus(OP_SRA, 2'd0, packSrc(5'd0, 5'd4, 5'd31), 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 0, 0, 1'b1);
    applyStimulus(OP_SRL, 2'd2, packSrc(5'd0, 5'd5, 5'd29), 32'hF000_0000, 32'h0000_0007, 1'b0, 9, 8, 2, 1'b1);
    applyStimulus(OP_SLL, 2'd1, packSrc(5'd0, 5'd5, 5'd31), 32'hDEAD_BEEF, 32'hD5B7_DDE0, 1'b0, 3, 2, 0, 1'b1);
    applyStimulus(OP_SRA, 2'd2, packSrc(5'd0, 5'd5, 5'd31), 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 9, 8, 0, 1'b1);
    applyStimulus(OP_ROR, 2'd2, packSrc(5'd0, 5'd5, 5'd31), 32'h0000_0001, 32'h0000_0002, 1'b0, 9, 8, 0, 1'b1);
    applyStimulus(OP_ROR, 2'd0, packSrc(5'd7, 5'd5, 5'd31), 32'h0000_00FF, 32'hFE00_0001, 1'b0, 3, 2, 0, 1'b1);

    // Reset during cycle 3 of an SRA by 31 abandons the operation silently.
    applyStimulus(OP_SRA, 2'd2, packSrc(5'd0, 5'd5, 5'd31), 32'h8000_0000, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_data_out", bus.data_out, 32'h0);
    checkOutput("midreset_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("midreset_done", {31'b0, bus.done}, 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    applyStimulus(OP_SRL, 2'd1, packSrc(5'd0, 5'd5, 5'd31), 32'h8000_0000, 32'h0400_0000, 1'b0, 3, 2, 0, 1'b1);

`ifdef MUX_SHIFT_ABORT_EN
    // Abort during cycle 4 of an SLL by 20 restores the operand and suppresses done.
    applyStimulus(OP_SLL, 2'd1, packSrc(5'd0, 5'd20, 5'd31), 32'h0000_0003, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_data_out", bus.data_out, 32'h0000_0003);
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'h0);
    repeat (10) @(negedge clk);
    applyStimulus(OP_SLL, 2'd1, packSrc(5'd0, 5'd4, 5'd31), 32'h0000_0003, 32'h0000_0030, 1'b0, 2, 1, 0, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
